// File: rtl/gen_pulso_multi_if.sv
// Purpose : key/pulse bundle between the board pushbuttons and the multi-key pulse generator.
// Latency : n/a (wires only).
// Backpressure: none; SALIDA/TICK are strobes with no ready signal.
// Ports   : KEY (raw keys), REPEAT_EN (per-key auto-repeat enable),
//           SALIDA (press/repeat pulses), NIVEL (debounced levels), TICK (sample strobe).
interface gen_pulso_multi_if #(
  parameter int N_KEYS = 4
) ();
  logic [N_KEYS-1:0] KEY;
  logic [N_KEYS-1:0] REPEAT_EN;
  logic [N_KEYS-1:0] SALIDA;
  logic [N_KEYS-1:0] NIVEL;
  logic              TICK;

  // master: the side that owns the keys (board / bench)
  modport master (output KEY, output REPEAT_EN, input SALIDA, input NIVEL, input TICK);
  // slave: the pulse generator
  modport slave  (input KEY, input REPEAT_EN, output SALIDA, output NIVEL, output TICK);
endinterface

// File: rtl/gen_pulso_multi.sv
// Purpose : N-key pushbutton front end: 2-flop sync, tick-sampled debounce, one-clock
//           press pulse per key with optional auto-repeat (initial delay, then fixed rate).
// Latency : press pulse 2 cycles + up to DEB_SAMPLES*TICK_DIV cycles after the key edge.
// Backpressure: none; pulses are fire-and-forget strobes.
// Ports   : CLK, RESET (async, active-low), io (slave side of gen_pulso_multi_if).
module gen_pulso_multi #(
  parameter int N_KEYS       = 4,
  parameter int TICK_DIV     = 100000,
  parameter int DEB_SAMPLES  = 4,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic              CLK,
  input  logic              RESET,
  gen_pulso_multi_if.slave  io
);

  localparam int PW   = $clog2(TICK_DIV + 1);
  localparam int DW   = $clog2(DEB_SAMPLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_SAMPLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } state_e;

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [PW-1:0]     pre_q;
  logic [PW-1:0]     pre_d;
  logic              run_q;
  logic              tick;
  logic [N_KEYS-1:0] nivel_vec;
  logic [N_KEYS-1:0] salida_vec;

  // Shared prescaler. run_q only matters for TICK_DIV=1, where the count is stuck at
  // its terminal value and would otherwise hold TICK high while in reset.
  always_comb begin
    pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
  end

  assign tick = run_q & (pre_q == PRE_LAST);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pre_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      sync1_q <= io.KEY;
      sync2_q <= sync1_q;
      pre_q   <= pre_d;
      run_q   <= 1'b1;
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    logic [DW-1:0] deb_cnt_q;
    logic [DW-1:0] deb_cnt_d;
    logic          nivel_q;
    logic          nivel_d;
    logic [RW-1:0] rcnt_q;
    logic [RW-1:0] rcnt_d;
    logic          salida_q;
    logic          salida_d;
    state_e        state_q;
    state_e        state_d;
    logic          differs;
    logic          accept;
    logic          rise;
    logic          fall;

    // Debounce: a level change is accepted on the DEB_SAMPLES-th consecutive
    // differing tick sample; any agreeing sample restarts the run.
    always_comb begin
      differs   = (sync2_q[g] != nivel_q);
      accept    = tick & differs & (deb_cnt_q == DEB_LAST);
      deb_cnt_d = deb_cnt_q;
      nivel_d   = nivel_q;
      if (tick) begin
        if (!differs) begin
          deb_cnt_d = '0;
        end else if (accept) begin
          deb_cnt_d = '0;
          nivel_d   = ~nivel_q;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      rise = accept & ~nivel_q;
      fall = accept &  nivel_q;
    end

    // Repeat FSM. Release and a dropped enable both win over a terminal tick,
    // so neither can ever produce a pulse.
    always_comb begin
      state_d  = state_q;
      rcnt_d   = rcnt_q;
      salida_d = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          rcnt_d = '0;
          if (rise) begin
            salida_d = 1'b1;
            if (io.REPEAT_EN[g]) state_d = S_DELAY;
          end
        end
        S_DELAY: begin
          if (fall || !io.REPEAT_EN[g]) begin
            state_d = S_IDLE;
            rcnt_d  = '0;
          end else if (tick) begin
            if (rcnt_q == DLY_LAST) begin
              salida_d = 1'b1;
              state_d  = S_REPEAT;
              rcnt_d   = '0;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
        end
        S_REPEAT: begin
          if (fall || !io.REPEAT_EN[g]) begin
            state_d = S_IDLE;
            rcnt_d  = '0;
          end else if (tick) begin
            if (rcnt_q == RPT_LAST) begin
              salida_d = 1'b1;
              rcnt_d   = '0;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        deb_cnt_q <= '0;
        nivel_q   <= 1'b0;
        rcnt_q    <= '0;
        salida_q  <= 1'b0;
        state_q   <= S_IDLE;
      end else begin
        deb_cnt_q <= deb_cnt_d;
        nivel_q   <= nivel_d;
        rcnt_q    <= rcnt_d;
        salida_q  <= salida_d;
        state_q   <= state_d;
      end
    end

    assign nivel_vec[g]  = nivel_q;
    assign salida_vec[g] = salida_q;
  end

  assign io.NIVEL  = nivel_vec;
  assign io.SALIDA = salida_vec;
  assign io.TICK   = tick;

endmodule

// File: doc/gen_pulso_multi.md
# gen_pulso_multi

Multi-channel pushbutton pulse generator. It synchronises N raw key inputs, debounces them against a shared sample-tick prescaler, and emits a one-clock pulse per press. Each channel has an optional auto-repeat mode (initial delay, then a fixed rate). It sits between the board pushbuttons and the control/processor logic and replaces the single-key pulse generator.

## Interface
- N_KEYS, 4: number of independent key channels (≥1).
- TICK_DIV, 100000: clock cycles per debounce sample tick (≥1; 1 ms at 100 MHz).
- DEB_SAMPLES, 4: consecutive equal samples required to accept a level change (≥1).
- REPEAT_DELAY, 500: ticks from the press pulse to the first repeat pulse (≥1).
- REPEAT_RATE, 100: ticks between successive repeat pulses (≥1).

- CLK  in  1  system clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-low reset; low clears all state immediately.
- KEY  in  N_KEYS  raw key inputs, active-high, asynchronous to CLK.
- REPEAT_EN  in  N_KEYS  per-channel auto-repeat enable; synchronous to CLK.
- SALIDA  out  N_KEYS  one-cycle press/repeat pulse per channel.
- NIVEL  out  N_KEYS  debounced key level per channel.
- TICK  out  1  one-cycle sample strobe, shared by all channels.

## Operation
- Reset (RESET=0): SALIDA=0, NIVEL=0, TICK=0, prescaler=0, all debounce and repeat counters=0, every FSM in IDLE.
- Synchroniser: a 2-flop chain per KEY bit. Debounce logic uses only the synchronised value.
- Prescaler: counts 0..TICK_DIV-1 and wraps. TICK=1 in the cycle where the count equals TICK_DIV-1. With TICK_DIV=1, TICK is high every cycle.
- Debounce, per channel, evaluated only on TICK cycles:
  - If the synchronised value equals NIVEL, clear the debounce count.
  - Otherwise increment it. When it reaches DEB_SAMPLES, toggle NIVEL and clear the count.
- Repeat FSM, per channel. States: IDLE, DELAY, REPEAT. A shared-width tick counter is cleared on every state entry.
  - IDLE: on a NIVEL 0→1 update, pulse SALIDA. If REPEAT_EN=1 go to DELAY, else stay in IDLE.
  - DELAY: count TICKs. At REPEAT_DELAY, pulse SALIDA and go to REPEAT.
  - REPEAT: count TICKs. At REPEAT_RATE, pulse SALIDA and restart the count.
  - A NIVEL 1→0 update in any state returns to IDLE with no pulse.
  - REPEAT_EN=0 while in DELAY or REPEAT returns to IDLE with no pulse. No further pulse occurs until the key is released and pressed again.
- Release never pulses SALIDA.
- Channels are fully independent. Simultaneous events on several channels produce pulses in the same cycle.
- A key already held at reset release counts as a new press: one pulse after debounce.
- Counter widths: $clog2(max+1) of the respective parameter. Counters never exceed their terminal value.

## Timing
- NIVEL and SALIDA are registered. They update on the clock edge that ends the TICK cycle and are visible in the following cycle.
- Press latency: 2 cycles (synchroniser) plus up to DEB_SAMPLES×TICK_DIV cycles.
  - SALIDA is high for exactly the one cycle in which NIVEL first reads 1.
- Repeat pulses are high for exactly one cycle, in the cycle after the terminal TICK.
- With REPEAT_EN=1 and the key held, pulses occur after debounce tick d, then d+REPEAT_DELAY, then every REPEAT_RATE ticks.
- TICK itself is combinational from the prescaler register. It is 0 during reset and first asserts TICK_DIV cycles after RESET goes high.
- RESET asserted mid-operation forces all outputs to 0 within the same cycle (asynchronous). Operation resumes from the full reset state.

## Test plan
All scenarios use N_KEYS=4, TICK_DIV=4, DEB_SAMPLES=3, REPEAT_DELAY=5, REPEAT_RATE=2.
- Reset release, KEY=0 → SALIDA=NIVEL=0 throughout; TICK high in cycle 4, 8, 12, … after release.
- Clean press on KEY[0], REPEAT_EN=0, held 40 ticks then released → exactly one SALIDA[0] pulse ≤ 2+12 cycles after the press edge; NIVEL[0] falls 3 ticks after release; no pulse on release.
- KEY[1] toggling every 5 cycles for 60 cycles, then held high → NIVEL[1] stays 0 and no pulse during bounce; a single pulse 3 ticks after the input settles.
- KEY[2] held with REPEAT_EN[2]=1 for 20 ticks → pulses after debounce ticks 3, 8, 10, 12, 14, 16, 18, 20. Dropping REPEAT_EN[2] at tick 13 → the pulses at 14 and later are absent.
- KEY[0] and KEY[3] rise in the same cycle → SALIDA[0] and SALIDA[3] pulse in the same cycle; SALIDA[1:2] stay 0.
- RESET low for 3 cycles during REPEAT on channel 2 with the key held → all outputs 0 immediately; after release, a fresh debounce, one press pulse, and the repeat delay restarts from 0.
